// File: rtl/jk_pkg.sv
// jk_cmd_gen shared types and defaults.
// FSM state encoding plus default debounce and lockout lengths.
package jk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DB_CYCLES_DEF = 4;
  localparam int HOLDOFF_DEF   = 8;

endpackage

// File: rtl/jk_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one button.
// o_rise is a registered pulse coincident with a 0->1 change of o_db.
module jk_debounce
  import jk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_db,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_s2 ^ r_db;
  assign w_done = w_diff &&
                  (r_cnt == CW'(DB_CYCLES - 1));

  // Synchronize, then accept s2 once it has disagreed long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_rise <= w_done & r_s2;
      if (w_done) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;

endmodule

// File: rtl/jk_cmd_gen.sv
// Turns debounced set/clear presses into one-cycle j/k commands.
// After each command a lockout discards further presses.
module jk_cmd_gen
  import jk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int HOLDOFF   = HOLDOFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_on,
  input  logic btn_off,
  output logic j,
  output logic k,
  output logic busy,
  output logic dropped
);

  localparam int HW =
    (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_hcnt;
  logic          w_last;
  logic          w_rise_on;
  logic          w_rise_off;
  logic          w_db_on;
  logic          w_db_off;
  logic          w_press;
  logic          w_j_nxt;
  logic          w_k_nxt;
  logic          w_drop_nxt;
  logic          r_j;
  logic          r_k;
  logic          r_drop;

  jk_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_on (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_on),
    .o_db  (w_db_on),
    .o_rise(w_rise_on)
  );

  jk_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db_off (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_off),
    .o_db  (w_db_off),
    .o_rise(w_rise_off)
  );

  assign w_press = w_rise_on | w_rise_off;
  assign w_last  = (r_hcnt == HW'(HOLDOFF - 1));

  // State register and lockout cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == HOLD && !w_last) begin
        r_hcnt <= r_hcnt + 1'b1;
      end else begin
        r_hcnt <= '0;
      end
    end
  end

  // Next state: any press locks out, lockout expires on count.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_press) w_state_nxt = HOLD;
      HOLD: if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: issue in IDLE, discard in HOLD.
  always_comb begin
    w_j_nxt    = 1'b0;
    w_k_nxt    = 1'b0;
    w_drop_nxt = 1'b0;
    if (r_state == IDLE) begin
      w_j_nxt = w_rise_on;
      w_k_nxt = w_rise_off;
    end else begin
      w_drop_nxt = w_press;
    end
  end

  // Register the command pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j    <= 1'b0;
      r_k    <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_j    <= w_j_nxt;
      r_k    <= w_k_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  assign j       = r_j;
  assign k       = r_k;
  assign dropped = r_drop;
  assign busy    = (r_state == HOLD);

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Self-checking bench for jk_cmd_gen.
// Directed scenarios then random bounce, against a timestamp model.
module tb_jk_cmd_gen;

  localparam int DB = 4;
  localparam int HO = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn_on;
  logic btn_off;
  logic j;
  logic k;
  logic busy;
  logic dropped;

  int checks   = 0;
  int failures = 0;

  jk_cmd_gen #(
    .DB_CYCLES(DB),
    .HOLDOFF  (HO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_on (btn_on),
    .btn_off(btn_off),
    .j      (j),
    .k      (k),
    .busy   (busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Reference model: per button, a raw-sample pipeline and the
  // edge index at which s2 last agreed with the accepted level.
  // Lockout is a window of HO edges starting at the accept edge.
  int   n = 0;
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_db [2];
  logic m_rise [2];
  int   m_agree [2];
  int   e_acc = -1000;
  logic exp_j = 0;
  logic exp_k = 0;
  logic exp_busy = 0;
  logic exp_drop = 0;

  task automatic model_edge(input logic on, input logic off,
                            input logic r);
    logic prev_busy;
    logic in [2];
    n++;
    in[0] = on;
    in[1] = off;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0;
        m_rise[b] = 0; m_agree[b] = n;
      end
      e_acc = -1000;
      exp_j = 0; exp_k = 0; exp_busy = 0; exp_drop = 0;
      return;
    end
    prev_busy = exp_busy;
    exp_j = 0; exp_k = 0; exp_drop = 0;
    if (m_rise[0] || m_rise[1]) begin
      if (prev_busy) exp_drop = 1;
      else begin
        exp_j = m_rise[0];
        exp_k = m_rise[1];
        e_acc = n;
      end
    end
    exp_busy = (n >= e_acc) && (n < e_acc + HO);
    for (int b = 0; b < 2; b++) begin
      m_rise[b] = 0;
      if (m_s2[b] == m_db[b]) m_agree[b] = n;
      else if (n - m_agree[b] == DB) begin
        m_db[b] = m_s2[b];
        m_rise[b] = m_s2[b];
        m_agree[b] = n;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = in[b];
    end
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0b exp=%0b edge=%0d",
             tag, obs, exp, n);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic on, input logic off,
                      input logic r);
    btn_on  = on;
    btn_off = off;
    rst     = r;
    @(posedge clk);
    model_edge(on, off, r);
    #1;
    chk("j", j, exp_j);
    chk("k", k, exp_k);
    chk("busy", busy, exp_busy);
    chk("dropped", dropped, exp_drop);
  endtask

  int   first_j;
  int   busy_cnt;
  int   hold_len;
  logic lv_on;
  logic lv_off;
  int   t_on;
  int   t_off;

  initial begin
    btn_on = 0; btn_off = 0; rst = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Held set button: j seven edges after rise, 8 busy cycles.
    first_j = -1; busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (j && first_j < 0) first_j = i;
      if (busy) busy_cnt++;
    end
    chk_int("latency_j", first_j, 7);
    chk_int("busy_len", busy_cnt, 8);
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Bounce then hold.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    first_j = -1;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (j && first_j < 0) first_j = i;
    end
    chk_int("bounce_latency", first_j, 7);
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Simultaneous presses: toggle.
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Clear press lands inside lockout: dropped, never issued.
    for (int i = 1; i <= 28; i++) step(1, (i >= 4), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Reset mid-HOLD with button still held.
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    step(1, 0, 1);
    first_j = -1;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (j && first_j < 0) first_j = i;
    end
    chk_int("rst_reissue", first_j, 7);
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    // Random bounce and holds with occasional reset.
    lv_on = 0; lv_off = 0; t_on = 0; t_off = 0;
    for (int i = 0; i < 1500; i++) begin
      if (t_on == 0) begin
        lv_on = 1'($urandom_range(0, 1));
        t_on  = $urandom_range(1, 12);
      end
      if (t_off == 0) begin
        lv_off = 1'($urandom_range(0, 1));
        t_off  = $urandom_range(1, 12);
      end
      t_on--;
      t_off--;
      step(lv_on, lv_off, ($urandom_range(0, 199) == 0));
    end
    hold_len = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
